// File: rtl/addsub_feeder_if.sv
// addsub_feeder_if
// Command/issue bundle between an upstream command source, the addsub_feeder
// operand-issue stage, and the addsub unit it drives.
//
// Signals (names as seen from the feeder):
//   iVALID, oREADY          command handshake
//   iOPCODE                 0 = add, 1 = subtract
//   iDATAIN1, iDATAIN2      8-bit operands
//   iSTALL                  downstream not accepting; suppresses issue
//   iFLUSH                  discard all buffered commands
//   oOPCODE, oDATAIN1/2     registered issued command (to addsub)
//   oISSUE                  one-cycle strobe: new command on the outputs
//   oLEVEL                  FIFO occupancy, log2(DEPTH)+1 bits
//   oISSUED                 wrapping count of issued commands, CNTW bits
//
// Modports:
//   master  command source / downstream side (drives the i* signals)
//   slave   the feeder itself (drives the o* signals)

interface addsub_feeder_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 16
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic            iVALID;
    logic            oREADY;
    logic            iOPCODE;
    logic [7:0]      iDATAIN1;
    logic [7:0]      iDATAIN2;
    logic            iSTALL;
    logic            iFLUSH;
    logic            oOPCODE;
    logic [7:0]      oDATAIN1;
    logic [7:0]      oDATAIN2;
    logic            oISSUE;
    logic [LW-1:0]   oLEVEL;
    logic [CNTW-1:0] oISSUED;

    modport master (
        output iVALID, iOPCODE, iDATAIN1, iDATAIN2, iSTALL, iFLUSH,
        input  oREADY, oOPCODE, oDATAIN1, oDATAIN2, oISSUE, oLEVEL, oISSUED
    );

    modport slave (
        input  iVALID, iOPCODE, iDATAIN1, iDATAIN2, iSTALL, iFLUSH,
        output oREADY, oOPCODE, oDATAIN1, oDATAIN2, oISSUE, oLEVEL, oISSUED
    );
endinterface

// File: rtl/addsub_feeder.sv
// addsub_feeder
// Operand-issue stage sitting directly in front of the addsub unit. Buffers
// {opcode, operand1, operand2} commands in a DEPTH-entry FIFO and issues them
// one per cycle as registered operands with a one-cycle oISSUE strobe,
// honouring a downstream stall and a flush. Keeps a wrapping count of issued
// commands.
//
// Ports:
//   iCLK  clock, all state updates on the rising edge
//   iRST  synchronous active-high reset, priority over everything
//   bus   addsub_feeder_if.slave carrying the handshake, operands, control
//         and status (see addsub_feeder_if for the signal list)
//
// Parameters:
//   DEPTH  FIFO entries, power of two, >= 2
//   CNTW   width of the issued-command counter

module addsub_feeder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 16
) (
    input  logic           iCLK,
    input  logic           iRST,
    addsub_feeder_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    state_t          state_q,   state_d;
    logic [PW-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [LW-1:0]   level_q,   level_d;
    cmd_t            mem_q [DEPTH];
    cmd_t            mem_d [DEPTH];
    cmd_t            out_q,     out_d;
    logic            issue_q,   issue_d;
    logic [CNTW-1:0] issued_q,  issued_d;

    logic full;
    logic empty;
    logic ready;
    logic push;
    logic pop;
    cmd_t in_cmd;

    assign full   = (level_q == LW'(DEPTH));
    assign empty  = (level_q == '0);
    // No full-bypass: a pop in the same cycle does not open the FIFO.
    assign ready  = !full;
    assign in_cmd = '{op: bus.iOPCODE, a: bus.iDATAIN1, b: bus.iDATAIN2};

    // Flush drops any concurrent push; issue only happens from RUN, so the
    // first edge after leaving IDLE or HOLD never issues.
    assign push = bus.iVALID && ready && !bus.iFLUSH;
    assign pop  = (state_q == RUN) && !empty && !bus.iSTALL && !bus.iFLUSH;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;
        out_d    = out_q;
        issue_d  = 1'b0;
        issued_d = issued_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_cmd;
        end

        if (bus.iFLUSH) begin
            // Operand outputs and the issue count are left untouched.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            state_d  = IDLE;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                out_d    = mem_q[rd_ptr_q];
                issue_d  = 1'b1;
                issued_d = issued_q + CNTW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (push) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.iSTALL && !empty) begin
                        state_d = HOLD;
                    end else if (pop && (level_q == LW'(1)) && !push) begin
                        state_d = IDLE;
                    end
                end
                HOLD: begin
                    if (!bus.iSTALL) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            out_q    <= '0;
            issue_q  <= 1'b0;
            issued_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            out_q    <= out_d;
            issue_q  <= issue_d;
            issued_q <= issued_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge iCLK) begin
        mem_q <= mem_d;
    end

    assign bus.oREADY   = ready;
    assign bus.oOPCODE  = out_q.op;
    assign bus.oDATAIN1 = out_q.a;
    assign bus.oDATAIN2 = out_q.b;
    assign bus.oISSUE   = issue_q;
    assign bus.oLEVEL   = level_q;
    assign bus.oISSUED  = issued_q;

endmodule

// File: tb/tb_addsub_feeder.sv
// tb_addsub_feeder
// Scoreboard bench for addsub_feeder (DEPTH=4, CNTW=4). Accepted commands are
// queued as expected issues; a negedge monitor pops and compares on every
// oISSUE. The main process also checks levels, ready, strobe timing and the
// issue counter at specific cycles.

module tb_addsub_feeder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNTW  = 4;

    logic clk = 1'b0;
    logic rst;

    addsub_feeder_if #(.DEPTH(DEPTH), .CNTW(CNTW)) bus ();

    addsub_feeder #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic [16:0] exp_q [$];
    logic [16:0] vec [10];
    logic [16:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a command and hold it until accepted (bounded).
    task automatic push(input logic [16:0] c);
        int unsigned n;
        bit done;
        n    = 0;
        done = 1'b0;
        bus.iVALID   = 1'b1;
        bus.iOPCODE  = c[16];
        bus.iDATAIN1 = c[15:8];
        bus.iDATAIN2 = c[7:0];
        while (!done && n < 50) begin
            if (bus.oREADY && !bus.iFLUSH) begin
                step();
                exp_q.push_back(c);
                done = 1'b1;
            end else begin
                step();
                n++;
            end
        end
        bus.iVALID = 1'b0;
        if (!done) check("push_timeout", 32'(1), 32'(0));
    endtask

    task automatic wait_empty();
        int unsigned n;
        n = 0;
        while (bus.oLEVEL != '0 && n < 50) begin
            step();
            n++;
        end
        check("drain_level", 32'(bus.oLEVEL), 32'd0);
        step();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: every issue must match the oldest accepted command.
    always @(negedge clk) begin
        if (bus.oISSUE === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL issue_unexpected: got issue %h_%h_%h expected none",
                         bus.oOPCODE, bus.oDATAIN1, bus.oDATAIN2);
            end else begin
                mon_exp = exp_q.pop_front();
                check("issue_cmd", 32'({bus.oOPCODE, bus.oDATAIN1, bus.oDATAIN2}), 32'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = {1'b0, 8'h10, 8'h20};
        vec[1] = {1'b1, 8'hFF, 8'h01};
        vec[2] = {1'b0, 8'h80, 8'h80};
        vec[3] = {1'b1, 8'h00, 8'hFF};
        vec[4] = {1'b0, 8'h5A, 8'hA5};
        vec[5] = {1'b1, 8'h7F, 8'h80};
        vec[6] = {1'b0, 8'hC3, 8'h3C};
        vec[7] = {1'b1, 8'h01, 8'h02};
        vec[8] = {1'b0, 8'hEE, 8'h11};
        vec[9] = {1'b1, 8'h42, 8'h24};

        bus.iVALID   = 1'b0;
        bus.iOPCODE  = 1'b0;
        bus.iDATAIN1 = '0;
        bus.iDATAIN2 = '0;
        bus.iSTALL   = 1'b0;
        bus.iFLUSH   = 1'b0;
        rst          = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_ready",  32'(bus.oREADY),   32'd1);
        check("rst_level",  32'(bus.oLEVEL),   32'd0);
        check("rst_issue",  32'(bus.oISSUE),   32'd0);
        check("rst_issued", 32'(bus.oISSUED),  32'd0);
        check("rst_data",   32'({bus.oOPCODE, bus.oDATAIN1, bus.oDATAIN2}), 32'd0);

        // 1: single command, one-cycle-late issue
        push({1'b0, 8'h01, 8'h03});
        check("t1_no_bypass", 32'(bus.oISSUE), 32'd0);
        check("t1_level1",    32'(bus.oLEVEL), 32'd1);
        step();
        check("t1_issue",  32'(bus.oISSUE), 32'd1);
        check("t1_data",   32'({bus.oOPCODE, bus.oDATAIN1, bus.oDATAIN2}), 32'h00103);
        check("t1_level0", 32'(bus.oLEVEL), 32'd0);
        check("t1_count",  32'(bus.oISSUED), 32'd1);
        step();
        check("t1_strobe_end", 32'(bus.oISSUE), 32'd0);

        // 2: stall, fill to full, 5th held off until space
        bus.iSTALL = 1'b1;
        for (int i = 0; i < 4; i++) push(vec[i]);
        check("t2_level_full", 32'(bus.oLEVEL), 32'd4);
        check("t2_ready_low",  32'(bus.oREADY), 32'd0);
        bus.iVALID   = 1'b1;
        bus.iOPCODE  = vec[4][16];
        bus.iDATAIN1 = vec[4][15:8];
        bus.iDATAIN2 = vec[4][7:0];
        step();
        step();
        check("t2_held_level", 32'(bus.oLEVEL), 32'd4);
        check("t2_held_issue", 32'(bus.oISSUE), 32'd0);
        bus.iSTALL = 1'b0;
        step();
        check("t2_hold_run_no_issue", 32'(bus.oISSUE), 32'd0);
        check("t2_hold_run_level",    32'(bus.oLEVEL), 32'd4);
        step();
        check("t2_first_issue", 32'(bus.oISSUE), 32'd1);
        check("t2_first_data",  32'(bus.oDATAIN1), 32'(vec[0][15:8]));
        check("t2_level3",      32'(bus.oLEVEL), 32'd3);
        check("t2_ready_back",  32'(bus.oREADY), 32'd1);
        step();
        exp_q.push_back(vec[4]);
        bus.iVALID = 1'b0;
        check("t2_push_pop_level", 32'(bus.oLEVEL), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("t2_consecutive", 32'(bus.oISSUE), 32'd1);
            step();
        end
        check("t2_last_issue", 32'(bus.oISSUE), 32'd1);
        step();
        check("t2_idle_issue", 32'(bus.oISSUE), 32'd0);
        check("t2_level0",     32'(bus.oLEVEL), 32'd0);
        check("t2_count",      32'(bus.oISSUED), 32'd6);

        // 3: ten back-to-back commands, pointers wrap twice
        do_reset();
        for (int i = 0; i < 10; i++) push(vec[i]);
        wait_empty();
        check("t3_count", 32'(bus.oISSUED), 32'd10);

        // 4: flush with a concurrent push
        bus.iSTALL = 1'b1;
        for (int i = 0; i < 3; i++) push(vec[i]);
        check("t4_level3", 32'(bus.oLEVEL), 32'd3);
        bus.iFLUSH   = 1'b1;
        bus.iVALID   = 1'b1;
        bus.iOPCODE  = 1'b1;
        bus.iDATAIN1 = 8'hAA;
        bus.iDATAIN2 = 8'hBB;
        step();
        bus.iFLUSH = 1'b0;
        bus.iVALID = 1'b0;
        bus.iSTALL = 1'b0;
        exp_q.delete();
        check("t4_level0", 32'(bus.oLEVEL), 32'd0);
        check("t4_ready",  32'(bus.oREADY), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("t4_no_issue", 32'(bus.oISSUE), 32'd0);
            step();
        end
        check("t4_level_stays0", 32'(bus.oLEVEL), 32'd0);
        check("t4_count",        32'(bus.oISSUED), 32'd10);
        check("t4_hold_outputs", 32'({bus.oOPCODE, bus.oDATAIN1, bus.oDATAIN2}), 32'(vec[9]));

        // 5: reset with two buffered entries and count 7
        do_reset();
        for (int i = 0; i < 7; i++) push(vec[i]);
        wait_empty();
        check("t5_count7", 32'(bus.oISSUED), 32'd7);
        bus.iSTALL = 1'b1;
        push(vec[7]);
        push(vec[8]);
        check("t5_level2", 32'(bus.oLEVEL), 32'd2);
        rst = 1'b1;
        step();
        rst        = 1'b0;
        bus.iSTALL = 1'b0;
        exp_q.delete();
        check("t5_data0",  32'({bus.oOPCODE, bus.oDATAIN1, bus.oDATAIN2}), 32'd0);
        check("t5_issue0", 32'(bus.oISSUE), 32'd0);
        check("t5_count0", 32'(bus.oISSUED), 32'd0);
        check("t5_level0", 32'(bus.oLEVEL), 32'd0);
        check("t5_ready1", 32'(bus.oREADY), 32'd1);
        step();
        check("t5_no_issue_after", 32'(bus.oISSUE), 32'd0);

        // 6: counter wrap (CNTW=4)
        for (int i = 0; i < 15; i++) push(vec[i % 10]);
        wait_empty();
        check("t6_count15", 32'(bus.oISSUED), 32'd15);
        push(vec[3]);
        wait_empty();
        check("t6_wrap0", 32'(bus.oISSUED), 32'd0);

        step();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/addsub_feeder.md
Name: addsub_feeder

Overview:
Operand-issue stage directly upstream of the addsub unit. Accepts {opcode, operand1, operand2} commands over a valid/ready handshake and buffers them in a small FIFO. Presents them to addsub one per cycle as registered, glitch-free operands with an issue strobe, and honours a downstream stall. Also keeps a running count of issued operations.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
CNTW, 16, width of the issued-operation counter.

Ports:
iCLK  in  1  clock; all state updates on the rising edge.
iRST  in  1  reset; synchronous, active-high.
iVALID  in  1  upstream command valid.
oREADY  out  1  feeder can accept a command.
iOPCODE  in  1  0 = add, 1 = subtract; passed through unchanged.
iDATAIN1  in  8  operand 1.
iDATAIN2  in  8  operand 2.
iSTALL  in  1  downstream not accepting; suppresses issue.
iFLUSH  in  1  discard all buffered commands.
oOPCODE  out  1  issued opcode; drives addsub iOPCODE.
oDATAIN1  out  8  issued operand 1; drives addsub iDATAIN1.
oDATAIN2  out  8  issued operand 2; drives addsub iDATAIN2.
oISSUE  out  1  one-cycle strobe: outputs carry a new command this cycle.
oLEVEL  out  log2(DEPTH)+1  current FIFO occupancy.
oISSUED  out  CNTW  count of issued commands; wraps modulo 2^CNTW.

Behaviour:
- Reset (iRST=1 at an edge):
  - Pointers, level, oOPCODE, oDATAIN1, oDATAIN2, oISSUE and oISSUED all go to 0.
  - FSM goes to IDLE.
  - iRST has priority over every other input. Reset mid-stream drops buffered commands and clears the count.
- Push: the command is written when iVALID=1 && oREADY=1 at an edge.
  - oREADY = (oLEVEL != DEPTH), combinational from registered state.
  - While full, oREADY=0 even if a pop happens in the same cycle; there is no full-bypass.
  - With iVALID=1 and oREADY=0, nothing is written. Upstream must hold its data.
- Pop/issue: occurs at an edge when the FIFO is non-empty, iSTALL=0, iFLUSH=0 and the FSM is in RUN.
  - The head entry is registered into oOPCODE/oDATAIN1/oDATAIN2, oISSUE=1 for the following cycle, and oISSUED increments.
  - In any cycle with no pop, oISSUE=0 and the operand outputs hold their last value.
- Latency: a command pushed at edge N is issued at edge N+1 at the earliest, so it is visible on the outputs in the cycle after N+1. Empty-FIFO push does not bypass to the outputs.
- Simultaneous push and pop, non-full: both take effect and oLEVEL is unchanged. Read and write pointers wrap modulo DEPTH.
- Throughput: one issue per cycle while data is available and iSTALL=0.
- iFLUSH=1 at an edge:
  - Pointers and level go to 0, and any push in that cycle is dropped.
  - The operand outputs hold their value, oISSUE=0, and oISSUED is unchanged.
  - FSM goes to IDLE.
- FSM:
  - IDLE: oLEVEL=0. Goes to RUN on a push.
  - RUN: issuing. Goes to HOLD if iSTALL=1 and the FIFO is non-empty. Goes to IDLE when the last entry pops with no concurrent push.
  - HOLD: no issue. Returns to RUN at the edge where iSTALL=0, with no issue at that same edge; issue resumes on the next edge.
  - From any state: iFLUSH goes to IDLE and iRST goes to IDLE.
- Transition timing: the FSM state is evaluated before the transition at each edge. The first edge after leaving IDLE or HOLD therefore never issues.
- Data integrity: opcode and operands are carried bit-exact, with no arithmetic in this block. FIFO order is strict.

Test Plan:
1. Reset, then push {0,8'h01,8'h03} with iSTALL=0 → oISSUE pulses exactly once, one cycle late, with oOPCODE=0, oDATAIN1=01, oDATAIN2=03. oISSUED=1 and oLEVEL returns to 0.
2. iSTALL=1 and push 5 commands with DEPTH=4 → oREADY drops after the 4th accept and oLEVEL=4. Release iSTALL → four issues in push order on consecutive cycles after the single HOLD→RUN cycle. The 5th command is accepted once oREADY=1 again.
3. Continuous push of 10 random ops with no stall → 10 issues, order preserved, oISSUED=10. Pointers wrap twice with no loss.
4. Fill 3 entries, assert iFLUSH for one cycle while iVALID=1 → oLEVEL=0 and no oISSUE afterwards. Outputs keep the last issued values and oISSUED is unchanged.
5. Assert iRST with 2 entries buffered and oISSUED=7 → the next cycle shows all outputs 0, oLEVEL=0 and oREADY=1.
6. Preload oISSUED to 16'hFFFF via 65535 issues (or CNTW=4: 15 issues), then issue one more → the count wraps to 0.
